// File: rtl/timer_prescaler.sv
// Clock-select / prescaler stage producing the timer count-enable pulse train
// from divided clock50 or synchronised T_pin edges (AVR CSn2:0 style).
module timer_prescaler #(
    parameter int unsigned PRESC_WIDTH = 10
) (
    input  logic                   clock50,
    input  logic                   MR,
    input  logic [2:0]             CS,
    input  logic                   PSR,
    input  logic                   T_pin,
    output logic                   CE_out,
    output logic [PRESC_WIDTH-1:0] PRESC_out
);

    localparam logic [2:0] CS_STOP    = 3'b000;
    localparam logic [2:0] CS_DIV1    = 3'b001;
    localparam logic [2:0] CS_DIV8    = 3'b010;
    localparam logic [2:0] CS_DIV64   = 3'b011;
    localparam logic [2:0] CS_DIV256  = 3'b100;
    localparam logic [2:0] CS_DIV1024 = 3'b101;
    localparam logic [2:0] CS_T_FALL  = 3'b110;
    localparam logic [2:0] CS_T_RISE  = 3'b111;
    localparam logic [1:0] ARM_MAX    = 2'd3;

    logic [PRESC_WIDTH-1:0] presc;
    logic                   sync1;
    logic                   sync2;
    logic                   prev;
    logic [1:0]             arm_cnt;
    logic                   armed;
    logic                   rise_evt;
    logic                   fall_evt;
    logic                   ce;

    // Free-running prescaler, pin synchroniser and arming counter
    always_ff @(posedge clock50) begin
        if (MR) begin
            presc   <= '0;
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            prev    <= 1'b0;
            arm_cnt <= 2'd0;
        end else begin
            presc   <= PSR ? '0 : presc + PRESC_WIDTH'(1);
            sync1   <= T_pin;
            sync2   <= sync1;
            prev    <= sync2;
            arm_cnt <= (arm_cnt == ARM_MAX) ? arm_cnt : arm_cnt + 2'd1;
        end
    end

    // Edges are ignored until the chain has flushed the reset zeros
    assign armed    = (arm_cnt == ARM_MAX);
    assign rise_evt = armed & sync2 & ~prev;
    assign fall_evt = armed & ~sync2 & prev;

    // Count-enable decode from registered state, CS and PSR only
    always_comb begin
        ce = 1'b0;
        if (!MR) begin
            case (CS)
                CS_STOP:    ce = 1'b0;
                CS_DIV1:    ce = 1'b1;
                CS_DIV8:    ce = ~PSR & (&presc[2:0]);
                CS_DIV64:   ce = ~PSR & (&presc[5:0]);
                CS_DIV256:  ce = ~PSR & (&presc[7:0]);
                CS_DIV1024: ce = ~PSR & (&presc[9:0]);
                CS_T_FALL:  ce = fall_evt;
                CS_T_RISE:  ce = rise_evt;
                default:    ce = 1'b0;
            endcase
        end
    end

    assign CE_out    = ce;
    assign PRESC_out = presc;

endmodule
